regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-read-port register file: the next generation of the processor's 8×16 two-read/one-write register file. It adds configurable width, depth and read-port count, optional write-to-read bypass and a hardwired-zero entry 0. It also adds a sequential bulk-clear engine that zeroes the array one entry per cycle on request. It sits between decode (read addresses) and writeback (write port) in the datapath.

## Interface
- WIDTH, 16, data bits per entry (≥1)
- DEPTH, 8, number of entries; power of two, ≥2
- NRD, 2, number of read ports (≥1)
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports
- ZERO_REG, 0, 1 = entry 0 always reads 0 and ignores writes and is not cleared
- Derived: AW = $clog2(DEPTH)

- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr_en  in  1  write request
- wr_addr  in  AW  write address
- wr_data  in  WIDTH  write data
- wr_rdy  out  1  write accepted this cycle; equals !clr_busy
- rd_addr  in  NRD*AW  packed read addresses; port i = bits [i*AW +: AW]
- rd_data  out  NRD*WIDTH  packed read data; port i = bits [i*WIDTH +: WIDTH]
- clr_req  in  1  start bulk clear; honoured only when idle
- clr_busy  out  1  clear in progress
- clr_done  out  1  one-cycle pulse when clear finishes

## Operation
- Reset (rst_n low, asynchronous):
  - all entries = 0
  - FSM = IDLE, clear counter = 0
  - clr_busy = 0, clr_done = 0, wr_rdy = 1
- Write: if wr_en && wr_rdy, then array[wr_addr] <= wr_data at the rising edge.
  - If wr_en && !wr_rdy, the write is dropped silently, with no state change.
- ZERO_REG=1: writes to address 0 are discarded, and reads of address 0 return 0 regardless of bypass.
- Read: combinational per port. rd_data[i] = array[rd_addr[i]], subject to the two overrides below.
  - Bypass: if BYPASS=1, wr_en, wr_rdy, wr_addr==rd_addr[i] and the address is not the ZERO_REG-protected entry 0, then rd_data[i] = wr_data.
  - A dropped write, i.e. one made during clear, is never bypassed.
- Multiple read ports addressing the same entry all return the same value.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR when clr_req=1 at an edge; the counter loads 0.
  - CLEAR: at each edge array[cnt] <= 0, then cnt <= cnt+1.
  - When cnt==DEPTH-1, the final entry is zeroed, the FSM returns to IDLE, clr_done <= 1 and cnt <= 0.
  - clr_done is deasserted at the following edge unless a new pass completes.
- clr_req while in CLEAR is ignored; no queuing and no restart.
- clr_req at the same edge as a write in IDLE: the write is performed (wr_rdy=1 that cycle), and the entry is then zeroed by the clear pass.
- Reads during CLEAR return current array contents: already-cleared entries read 0, and pending entries keep their old values.
- Reset asserted mid-clear aborts the pass. The array is zero from reset anyway, and clr_done does not pulse.

## Timing
- Read latency: 0 cycles (combinational from rd_addr, and from wr_* when BYPASS=1).
- Write latency: 1 edge. Without bypass, the value is visible on reads the cycle after the write edge.
- Clear request sampled at edge E0:
  - clr_busy = 1 from after E0 until after edge E0+DEPTH; that is DEPTH cycles.
  - Entry k is zeroed at edge E0+1+k.
  - clr_done = 1 for exactly the cycle after edge E0+DEPTH.
- wr_rdy = !clr_busy, combinational from state.
- Back-to-back clear: a clr_req held high through the clr_done cycle starts the next pass at the edge ending that cycle, because the FSM is IDLE then.
- The counter is AW bits wide and stops at DEPTH-1; it never wraps inside a pass.

## Test plan
- Reset/read: assert rst_n=0 mid-simulation with nonzero contents -> all rd_data = 0 immediately; clr_busy=0, clr_done=0, wr_rdy=1.
- Write/read + bypass (defaults): write 0xBEEF to addr 5 while rd_addr port0=5 -> rd_data0=0xBEEF in the same cycle. With BYPASS=0, the old value is returned that cycle and 0xBEEF the next.
- Multi-port: NRD=3, write 0x1111/0x2222/0x3333 to addrs 1/2/3, then read ports {3,1,3} -> 0x3333, 0x1111, 0x3333.
- ZERO_REG=1: write 0xFFFF to addr 0 with a same-cycle read of addr 0 -> 0 both that cycle and after.
- Bulk clear (DEPTH=8): fill with 0xA5A5, pulse clr_req at E0.
  - clr_busy is high for 8 cycles; entry 3 reads 0xA5A5 before edge E0+4 and 0 after.
  - A write to addr 7 at cycle 2 is dropped (wr_rdy=0).
  - clr_done pulses once after E0+8, and all entries then read 0.
- Reset mid-clear: assert rst_n=0 at cycle 3 of a pass -> clr_busy=0 immediately, no clr_done pulse, all entries 0. A new clr_req after release completes normally.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-read-port register file with bypass, zero entry and bulk clear
module regfile_mp #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int NRD = 2,
  parameter int BYPASS = 1,
  parameter int ZERO_REG = 0,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  output logic                 wr_rdy,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*WIDTH-1:0] rd_data,
  input  logic                 clr_req,
  output logic                 clr_busy,
  output logic                 clr_done
);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state;
  logic [AW-1:0] cnt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic wr_ok;
  assign clr_busy = state == CLEAR;
  assign wr_rdy = !clr_busy;
  assign wr_ok = wr_en && wr_rdy;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      if (state == IDLE) begin
        if (clr_req) begin
          state <= CLEAR;
          cnt <= '0;
        end
      end else if (cnt == AW'(DEPTH - 1)) begin
        state <= IDLE;
        cnt <= '0;
        clr_done <= 1'b1;
      end else begin
        cnt <= cnt + AW'(1);
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_ok && !((ZERO_REG != 0) && wr_addr == '0)) mem[wr_addr] <= wr_data;
      if (clr_busy && !((ZERO_REG != 0) && cnt == '0)) mem[cnt] <= '0;
    end
  end
  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0] ra;
    assign ra = rd_addr[g*AW +: AW];
    assign rd_data[g*WIDTH +: WIDTH] =
      ((ZERO_REG != 0) && ra == '0)                 ? '0      :
      ((BYPASS != 0) && wr_ok && wr_addr == ra)      ? wr_data :
                                                      mem[ra];
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized scoreboard bench for two regfile_mp configurations
module tb_regfile_mp;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [8:0] rd_addr = '0;
  logic clr_req = 1'b0;
  logic [47:0] rd_data0;
  logic [31:0] rd_data1;
  logic rdy0, busy0, done0, rdy1, busy1, done1;
  always #5 clk = ~clk;
  regfile_mp #(.WIDTH(16), .DEPTH(8), .NRD(3), .BYPASS(1), .ZERO_REG(0)) u0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_rdy(rdy0), .rd_addr(rd_addr), .rd_data(rd_data0), .clr_req(clr_req),
    .clr_busy(busy0), .clr_done(done0));
  regfile_mp #(.WIDTH(16), .DEPTH(8), .NRD(2), .BYPASS(0), .ZERO_REG(1)) u1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_rdy(rdy1), .rd_addr(rd_addr[5:0]), .rd_data(rd_data1), .clr_req(clr_req),
    .clr_busy(busy1), .clr_done(done1));
  typedef struct packed {
    logic [47:0] rd0;
    logic [31:0] rd1;
    logic busy;
    logic done;
    logic rdy;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  logic [15:0] m0 [8];
  logic [15:0] m1 [8];
  int left = 0;
  bit done_f = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("rd_data0", 64'(rd_data0), 64'(e.rd0));
      chk("rd_data1", 64'(rd_data1), 64'(e.rd1));
      chk("clr_busy0", 64'(busy0), 64'(e.busy));
      chk("clr_busy1", 64'(busy1), 64'(e.busy));
      chk("clr_done0", 64'(done0), 64'(e.done));
      chk("clr_done1", 64'(done1), 64'(e.done));
      chk("wr_rdy0", 64'(rdy0), 64'(e.rdy));
      chk("wr_rdy1", 64'(rdy1), 64'(e.rdy));
    end
  end
  task automatic cycle(input bit we, input logic [2:0] wa, input logic [15:0] wd,
                       input logic [8:0] ra, input bit clr, input bit rst);
    exp_t e;
    bit busy;
    logic [2:0] a;
    @(posedge clk);
    #1;
    rst_n = !rst;
    wr_en = we && !rst;
    wr_addr = wa;
    wr_data = wd;
    rd_addr = ra;
    clr_req = clr;
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        m0[i] = '0;
        m1[i] = '0;
      end
      left = 0;
      done_f = 0;
    end
    busy = left > 0;
    for (int p = 0; p < 3; p++) begin
      a = ra[p*3 +: 3];
      e.rd0[p*16 +: 16] = (wr_en && !busy && wa == a) ? wd : m0[a];
    end
    for (int p = 0; p < 2; p++) begin
      a = ra[p*3 +: 3];
      e.rd1[p*16 +: 16] = (a == 0) ? 16'h0 : m1[a];
    end
    e.busy = busy;
    e.done = done_f;
    e.rdy = !busy;
    q.push_back(e);
    if (!rst) begin
      if (busy) begin
        m0[8 - left] = '0;
        m1[8 - left] = '0;
        left--;
        done_f = left == 0;
      end else begin
        done_f = 0;
        if (wr_en) begin
          m0[wa] = wd;
          if (wa != 0) m1[wa] = wd;
        end
        if (clr) left = 8;
      end
    end
  endtask
  task automatic fill(input logic [15:0] v);
    for (int i = 0; i < 8; i++) cycle(1, 3'(i), v, 9'(i), 0, 0);
  endtask
  initial begin
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    cycle(1, 5, 16'hBEEF, {3'd0, 3'd5, 3'd5}, 0, 0);
    cycle(0, 0, 0, {3'd0, 3'd5, 3'd5}, 0, 0);
    cycle(1, 1, 16'h1111, 0, 0, 0);
    cycle(1, 2, 16'h2222, 0, 0, 0);
    cycle(1, 3, 16'h3333, 0, 0, 0);
    cycle(0, 0, 0, {3'd3, 3'd1, 3'd3}, 0, 0);
    cycle(1, 0, 16'hFFFF, {3'd0, 3'd0, 3'd0}, 0, 0);
    cycle(0, 0, 0, {3'd0, 3'd0, 3'd0}, 0, 0);
    cycle(0, 0, 0, {3'd0, 3'd1, 3'd3}, 1, 1);
    cycle(0, 0, 0, {3'd0, 3'd1, 3'd3}, 0, 0);
    fill(16'hA5A5);
    cycle(0, 0, 0, 9'd3, 1, 0);
    for (int c = 0; c < 10; c++) cycle(c == 2, 7, 16'h7777, {3'd7, 3'd7, 3'd3}, 0, 0);
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, {3'(i), 3'(i), 3'(i)}, 0, 0);
    fill(16'h5A5A);
    cycle(0, 0, 0, 9'd4, 1, 0);
    cycle(0, 0, 0, 9'd4, 0, 0);
    cycle(0, 0, 0, 9'd4, 0, 0);
    cycle(0, 0, 0, {3'd6, 3'd5, 3'd4}, 0, 1);
    cycle(0, 0, 0, {3'd6, 3'd5, 3'd4}, 0, 0);
    fill(16'h1234);
    cycle(0, 0, 0, 0, 1, 0);
    for (int c = 0; c < 10; c++) cycle(0, 0, 0, {3'd2, 3'd1, 3'd0}, 0, 0);
    fill(16'hC3C3);
    for (int c = 0; c < 20; c++) cycle(1, 3'(c), 16'(c), {3'(c), 3'd7, 3'd1}, 1, 0);
    for (int c = 0; c < 2000; c++)
      cycle($urandom_range(9) < 6, 3'($urandom), 16'($urandom), 9'($urandom),
            $urandom_range(24) == 0, $urandom_range(199) == 0);
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
